// File: rtl/code_defs_pkg.sv
// code_defs_pkg: XGMII control characters, MAC preamble/SFD bytes and the CRC-32 residue
// seen in the uninverted register after a frame and its FCS have been fed through.
package code_defs_pkg;
  localparam logic [7:0] RS_START = 8'hFB;
  localparam logic [7:0] RS_TERM = 8'hFD;
  localparam logic [7:0] RS_IDLE = 8'h07;
  localparam logic [7:0] RS_ERROR = 8'hFE;
  localparam logic [7:0] MAC_PRE = 8'h55;
  localparam logic [7:0] MAC_SFD = 8'hD5;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
endpackage

// File: rtl/rx_term_decode.sv
// rx_term_decode: finds the first control lane of an XGMII word and classifies it as a
// well-placed TERM or as a control error.
module rx_term_decode
  import code_defs_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [3:0]  i_ctl,
  output logic [1:0]  o_lane,
  output logic        o_term,
  output logic        o_err
);
  always_comb begin
    o_lane = i_ctl[0] ? 2'd0 : i_ctl[1] ? 2'd1 : i_ctl[2] ? 2'd2 : 2'd3;
    o_term = |i_ctl && i_data[8*o_lane +: 8] == RS_TERM;
    o_err = |i_ctl && !o_term;
  end
endmodule

// File: rtl/slicing_crc.sv
// slicing_crc: reflected CRC-32 (poly 0xEDB88320) over up to SLICE_LENGTH bytes per cycle,
// lane 0 first; i_clear reloads INITIAL_CRC synchronously.
module slicing_crc #(
  parameter int SLICE_LENGTH = 4,
  parameter logic [31:0] INITIAL_CRC = 32'hFFFFFFFF,
  parameter bit INVERT_OUTPUT = 1'b0,
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic [8*SLICE_LENGTH-1:0] i_data,
  input  logic [SLICE_LENGTH-1:0]   i_valid,
  output logic [31:0]               o_crc
);
  logic [31:0] r_crc, w_nxt;
  always_comb begin
    w_nxt = r_crc;
    for (int i = 0; i < SLICE_LENGTH; i++)
      if (i_valid[i]) begin
        w_nxt = w_nxt ^ {24'd0, i_data[8*i +: 8]};
        for (int j = 0; j < 8; j++) w_nxt = w_nxt[0] ? (w_nxt >> 1) ^ 32'hEDB88320 : w_nxt >> 1;
      end
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) r_crc <= INITIAL_CRC;
    else r_crc <= i_clear ? INITIAL_CRC : w_nxt;
  assign o_crc = (REGISTER_OUTPUT ? r_crc : w_nxt) ^ {32{INVERT_OUTPUT}};
endmodule

// File: rtl/rx_mac.sv
// rx_mac: 10G receive MAC, XGMII words in, AXI-Stream payload out with CRC/length verdict on tuser.
// Define RX_MAC_STATS_EN to add rx_good_frames / rx_bad_frames counters.
module rx_mac
  import code_defs_pkg::*;
#(
  parameter int MIN_FRAME_SIZE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] xgmii_rx_data,
  input  logic [3:0]  xgmii_rx_ctl,
  input  logic        phy_rx_valid,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  output logic        m00_axis_tlast,
  output logic        m00_axis_tuser
`ifdef RX_MAC_STATS_EN
  ,
  output logic [31:0] rx_good_frames,
  output logic [31:0] rx_bad_frames
`endif
);
  localparam int DATA_WIDTH = 32;
  localparam int DATA_NBYTES = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, ERROR} rx_state_t;
  rx_state_t r_state, w_nxt_state;
  logic [DATA_WIDTH-1:0] r_a, r_b, w_a, w_b, w_odata, r_tdata;
  logic [DATA_NBYTES-1:0] r_dkeep, w_dkeep, w_okeep, w_kmask, w_feed, r_tkeep;
  logic r_a_vld, r_b_vld, w_av, w_bv, r_drain, w_drain;
  logic w_ovld, w_olast, w_ouser, w_short, r_tvalid, r_tlast, r_tuser;
  logic [15:0] r_cnt, w_cnt;
  logic [16:0] w_sum;
  logic [1:0] w_lane;
  logic w_term, w_cerr, w_start, w_sfd, w_bad;
  logic [31:0] w_crc;
  rx_term_decode u_dec (.i_data(xgmii_rx_data), .i_ctl(xgmii_rx_ctl), .o_lane(w_lane), .o_term(w_term), .o_err(w_cerr));
  assign w_start = xgmii_rx_ctl == 4'b0001 && xgmii_rx_data == {MAC_PRE, MAC_PRE, MAC_PRE, RS_START};
  assign w_sfd = xgmii_rx_ctl == 4'b0000 && xgmii_rx_data == {MAC_SFD, MAC_PRE, MAC_PRE, MAC_PRE};
  assign w_kmask = ~(4'hF << w_lane);
  assign w_feed = w_term ? w_kmask : xgmii_rx_ctl == 4'h0 ? 4'hF : 4'h0;
  assign w_sum = {1'b0, r_cnt} + (w_term ? {15'd0, w_lane} : 17'd4);
  assign w_bad = w_crc != CRC32_RESIDUE || r_cnt < 16'(MIN_FRAME_SIZE);
  // The CRC stays clear in IDLE except on the drain cycle, whose verdict still needs it.
  slicing_crc #(.SLICE_LENGTH(4), .INITIAL_CRC(32'hFFFFFFFF), .INVERT_OUTPUT(1'b0), .REGISTER_OUTPUT(1'b1)) u_crc (
    .clk(clk), .i_rst_n(reset), .i_clear(r_state == IDLE && !r_drain), .i_data(xgmii_rx_data),
    .i_valid(phy_rx_valid && r_state == DATA ? w_feed : 4'h0), .o_crc(w_crc));
  always_comb begin
    w_nxt_state = r_state;
    w_a = r_a;
    w_b = r_b;
    w_av = r_a_vld;
    w_bv = r_b_vld;
    w_cnt = r_cnt;
    w_drain = 1'b0;
    w_dkeep = r_dkeep;
    w_odata = r_b;
    w_okeep = 4'hF;
    w_ovld = 1'b0;
    w_olast = 1'b0;
    w_ouser = 1'b0;
    w_short = 1'b0;
    case (r_state)
      IDLE: begin
        w_odata = r_a;
        w_okeep = r_dkeep;
        w_ovld = r_drain;
        w_olast = r_drain;
        w_ouser = r_drain && w_bad;
        w_nxt_state = !r_drain && w_start ? PREAMBLE : IDLE;
      end
      PREAMBLE: begin
        w_nxt_state = w_sfd ? DATA : IDLE;
        w_cnt = '0;
        w_av = 1'b0;
        w_bv = 1'b0;
      end
      DATA: begin
        w_cnt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        if (w_cerr) begin
          w_ovld = r_b_vld;
          w_olast = r_b_vld;
          w_ouser = r_b_vld;
          w_nxt_state = ERROR;
        end else if (w_term) begin
          w_short = !r_b_vld;
          w_ovld = r_b_vld;
          w_olast = r_b_vld && w_lane == 2'd0;
          w_ouser = r_b_vld && w_lane == 2'd0 && w_bad;
          w_drain = r_b_vld && w_lane != 2'd0;
          w_dkeep = w_kmask;
          w_nxt_state = IDLE;
        end else begin
          w_a = xgmii_rx_data;
          w_b = r_a;
          w_av = 1'b1;
          w_bv = r_a_vld;
          w_ovld = r_b_vld;
        end
      end
      ERROR: w_nxt_state = &xgmii_rx_ctl ? IDLE : ERROR;
      default: w_nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else if (phy_rx_valid) r_state <= w_nxt_state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {r_a, r_b, r_a_vld, r_b_vld, r_cnt, r_drain, r_dkeep} <= '0;
      {r_tdata, r_tkeep, r_tvalid, r_tlast, r_tuser} <= '0;
    end else if (phy_rx_valid) begin
      {r_a, r_b, r_a_vld, r_b_vld, r_cnt, r_drain, r_dkeep} <= {w_a, w_b, w_av, w_bv, w_cnt, w_drain, w_dkeep};
      {r_tdata, r_tkeep, r_tvalid, r_tlast, r_tuser} <= {w_odata, w_okeep, w_ovld, w_olast, w_ouser};
    end else begin
      r_tvalid <= 1'b0;
      r_tlast <= 1'b0;
      r_tuser <= 1'b0;
    end
  assign m00_axis_tdata = r_tdata;
  assign m00_axis_tkeep = r_tkeep;
  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tlast = r_tlast;
  assign m00_axis_tuser = r_tuser;
`ifdef RX_MAC_STATS_EN
  logic [31:0] r_good, r_bad;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_good <= '0;
      r_bad <= '0;
    end else if (phy_rx_valid) begin
      r_good <= r_good + 32'(w_ovld && w_olast && !w_ouser);
      r_bad <= r_bad + 32'((w_ovld && w_olast && w_ouser) || w_short);
    end
  assign rx_good_frames = r_good;
  assign rx_bad_frames = r_bad;
`endif
endmodule
